// File: rtl/l2_cache_pkg.sv
// Shared types and constants for the L2 physical-memory side.
// Contents: line/beat geometry, line/beat/address typedefs, adaptor FSM
// state enum, and a line-alignment helper.
package l2_cache_pkg;

  localparam int unsigned LINE_W     = 256;
  localparam int unsigned BURST_W    = 64;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned BEATS      = LINE_W / BURST_W;
  localparam int unsigned BEAT_IDX_W = $clog2(BEATS);
  localparam int unsigned OFFSET_W   = $clog2(LINE_W / 8);

  typedef logic [LINE_W-1:0]     line_t;
  typedef logic [BURST_W-1:0]    beat_t;
  typedef logic [BEAT_IDX_W-1:0] beat_idx_t;
  typedef logic [ADDR_W-1:0]     addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } adaptor_state_t;

  // Clear the byte-offset-within-line bits.
  function automatic addr_t line_align(input addr_t a);
    return {a[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
  endfunction

endpackage

// File: rtl/l2_line_shift_buffer.sv
// One-line buffer addressed in BURST_W beats.
// Ports:
//   clk, rst_n        clock, async active-low reset (buffer clears to 0)
//   i_load, i_line    load a whole line (takes priority over a beat write)
//   i_beat_we         write i_beat_data into beat i_beat_idx
//   i_beat_idx        beat index for both write-in and read-out
//   i_beat_data       incoming beat
//   o_beat_c          current contents of beat i_beat_idx (combinational)
//   o_line_merge_c    buffer with this cycle's beat write already applied
module l2_line_shift_buffer
  import l2_cache_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_load,
  input  line_t     i_line,
  input  logic      i_beat_we,
  input  beat_idx_t i_beat_idx,
  input  beat_t     i_beat_data,
  output beat_t     o_beat_c,
  output line_t     o_line_merge_c
);

  logic [BEATS-1:0][BURST_W-1:0] r_line;
  logic [BEATS-1:0][BURST_W-1:0] w_merge;

  // Next-line view: lets the owner capture a complete line on the last beat.
  always_comb begin
    w_merge = r_line;
    if (i_beat_we) begin
      w_merge[i_beat_idx] = i_beat_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line <= '0;
    end else if (i_load) begin
      r_line <= i_line;
    end else if (i_beat_we) begin
      r_line <= w_merge;
    end
  end

  assign o_beat_c       = r_line[i_beat_idx];
  assign o_line_merge_c = line_t'(w_merge);

endmodule

// File: rtl/l2_cacheline_adaptor.sv
// Responder for L2 whole-line pmem requests; issues BEATS-beat bursts to
// main memory and returns a one-cycle pmem_resp when the line is done.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   pmem_read/pmem_write       L2 line request (held until pmem_resp)
//   pmem_address, pmem_wdata   L2 line address / write line
//   pmem_rdata, pmem_resp      assembled read line / completion pulse
//   mem_read/mem_write         burst request to memory
//   mem_address                line-aligned burst address
//   mem_wdata                  current write beat (combinational from counter)
//   mem_rdata, mem_resp        current read beat / per-beat acknowledge
//   rd_count, wr_count         completed line reads/writes
// Build option: define L2_CACHELINE_ADAPTOR_PERF_EN to build the line
// counters; otherwise rd_count/wr_count are tied to 0.
module l2_cacheline_adaptor
  import l2_cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               pmem_read,
  input  logic               pmem_write,
  input  logic [ADDR_W-1:0]  pmem_address,
  input  logic [LINE_W-1:0]  pmem_wdata,
  output logic [LINE_W-1:0]  pmem_rdata,
  output logic               pmem_resp,
  output logic               mem_read,
  output logic               mem_write,
  output logic [ADDR_W-1:0]  mem_address,
  output logic [BURST_W-1:0] mem_wdata,
  input  logic [BURST_W-1:0] mem_rdata,
  input  logic               mem_resp,
  output logic [31:0]        rd_count,
  output logic [31:0]        wr_count
);

  adaptor_state_t r_state;
  beat_idx_t      r_beat;
  addr_t          r_addr;
  logic           r_mem_read;
  logic           r_mem_write;
  logic           r_pmem_resp;
  line_t          r_rdata;

  logic           w_load;
  logic           w_beat_we;
  logic           w_last;
  beat_t          w_beat;
  line_t          w_line_merge;

  assign w_load    = (r_state == IDLE) && pmem_write;
  assign w_beat_we = (r_state == READ) && mem_resp;
  assign w_last    = (r_beat == BEAT_IDX_W'(BEATS - 1));

  l2_line_shift_buffer u_buf (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_load         (w_load),
    .i_line         (pmem_wdata),
    .i_beat_we      (w_beat_we),
    .i_beat_idx     (r_beat),
    .i_beat_data    (mem_rdata),
    .o_beat_c       (w_beat),
    .o_line_merge_c (w_line_merge)
  );

  // Adaptor FSM; write wins when both requests are high in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_beat      <= '0;
      r_addr      <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_pmem_resp <= 1'b0;
      r_rdata     <= '0;
    end else begin
      r_pmem_resp <= 1'b0;
      case (r_state)
        IDLE: begin
          if (pmem_write) begin
            r_state     <= WRITE;
            r_mem_write <= 1'b1;
            r_addr      <= line_align(pmem_address);
            r_beat      <= '0;
          end else if (pmem_read) begin
            r_state    <= READ;
            r_mem_read <= 1'b1;
            r_addr     <= line_align(pmem_address);
            r_beat     <= '0;
          end
        end
        READ: begin
          if (mem_resp) begin
            r_beat <= BEAT_IDX_W'(r_beat + 1'b1);
            if (w_last) begin
              r_state     <= DONE;
              r_mem_read  <= 1'b0;
              r_pmem_resp <= 1'b1;
              // Capture including the beat arriving this cycle.
              r_rdata     <= w_line_merge;
            end
          end
        end
        WRITE: begin
          if (mem_resp) begin
            r_beat <= BEAT_IDX_W'(r_beat + 1'b1);
            if (w_last) begin
              r_state     <= DONE;
              r_mem_write <= 1'b0;
              r_pmem_resp <= 1'b1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign pmem_rdata  = r_rdata;
  assign pmem_resp   = r_pmem_resp;
  assign mem_read    = r_mem_read;
  assign mem_write   = r_mem_write;
  assign mem_address = r_addr;
  assign mem_wdata   = (r_state == WRITE) ? w_beat : '0;

`ifdef L2_CACHELINE_ADAPTOR_PERF_EN
  logic        r_is_write;
  logic [31:0] r_rd_count;
  logic [31:0] r_wr_count;

  // Line counters bump on leaving DONE; r_is_write remembers the accepted kind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_write <= 1'b0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      if (r_state == IDLE) begin
        r_is_write <= pmem_write;
      end
      if (r_state == DONE) begin
        if (r_is_write) begin
          r_wr_count <= r_wr_count + 32'd1;
        end else begin
          r_rd_count <= r_rd_count + 32'd1;
        end
      end
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;
`else
  assign rd_count = '0;
  assign wr_count = '0;
`endif

endmodule
